nco_freq_meter: RTL and testbench

Receive-side companion to the sine NCO. Samples the 4-bit offset-binary waveform the NCO drives to its DAC, either looped back or from a 4-bit ADC. Detects rising midpoint crossings and measures the average period, in clocks, over 2^LOG2_NPER periods. Used for closed-loop self-test of the NCO frequency word and as a standalone tone period meter.

---
 rtl/nco_freq_meter.sv | 221 ++++++++++++++++++++++
 tb/tb_nco_freq_meter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_freq_meter.sv
// ---------------------------------------------------------------------------
// NcoFreqMeter (module nco_freq_meter)
//
// Tone period meter for the 4-bit offset-binary sine NCO output, either
// looped back from the NCO or taken from a 4-bit ADC. Rising crossings of the
// midpoint are detected, and the average period in clocks is measured over
// 2^LOG2_NPER consecutive periods.
//
// Optional build macro:
//   FREQ_METER_HYST_EN - when defined, crossings use a hysteresis pair
//                        (LO_TH arms, HI_TH fires) instead of the single MID
//                        threshold, which rejects LSB noise near midpoint.
//
// Parameters:
//   PERIOD_W   width of period_avg
//   LOG2_NPER  log2 of the number of periods averaged per measurement
//   TIMEOUT_W  2^TIMEOUT_W-1 clocks without a crossing is a timeout
//   MID        midpoint threshold (single-threshold build)
//   HI_TH      upper hysteresis threshold (hysteresis build)
//   LO_TH      lower hysteresis threshold (hysteresis build)
//
// Ports:
//   sys_clk     in   system clock, all logic on the rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   start       in   one-cycle pulse arming a measurement, ignored while busy
//   sample_in   in   4-bit waveform sample, one per clock, offset binary
//   busy        out  high while a measurement is in progress (through DONE)
//   meas_valid  out  one-cycle pulse, period_avg freshly updated
//   period_avg  out  average period in clocks, held between measurements
//   no_signal   out  sticky timeout flag, cleared by the next accepted start
// ---------------------------------------------------------------------------
module nco_freq_meter #(
    parameter int PERIOD_W  = 24,
    parameter int LOG2_NPER = 3,
    parameter int TIMEOUT_W = 24,
    parameter int MID       = 8,
    parameter int HI_TH     = 10,
    parameter int LO_TH     = 5
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                start,
    input  logic [3:0]          sample_in,
    output logic                busy,
    output logic                meas_valid,
    output logic [PERIOD_W-1:0] period_avg,
    output logic                no_signal
);

    localparam int TOT_W  = PERIOD_W + LOG2_NPER;
    localparam int TOTP_W = TOT_W + 1;
    localparam int PER_W  = LOG2_NPER + 1;

    // Value of perCnt_q at which the next crossing completes the measurement.
    localparam logic [PER_W-1:0]     NPER_LAST = PER_W'((1 << LOG2_NPER) - 1);
    // Timeout fires on the edge where the counter would reach all-ones.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST  = ~TIMEOUT_W'(1);

    localparam logic [3:0] MID_Q = 4'(MID);
    localparam logic [3:0] HI_Q  = 4'(HI_TH);
    localparam logic [3:0] LO_Q  = 4'(LO_TH);

    // Threshold ordering is checked at elaboration so a bad override fails
    // loudly instead of producing a meter that never fires.
    if (!((LO_TH < MID) && (MID <= HI_TH) && (HI_TH <= 15) && (LO_TH >= 0)))
    begin : gBadThresholds
        $error("nco_freq_meter: thresholds must satisfy 0 <= LO_TH < MID <= HI_TH <= 15");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q,     state_d;
    logic [TOT_W-1:0]      totCnt_q,    totCnt_d;
    logic [PER_W-1:0]      perCnt_q,    perCnt_d;
    logic [TIMEOUT_W-1:0]  tmoCnt_q,    tmoCnt_d;
    logic [PERIOD_W-1:0]   periodAvg_q, periodAvg_d;
    logic                  noSignal_q,  noSignal_d;
    logic [3:0]            sample_q;
    logic                  xing;

    logic [TOT_W-1:0]      totInc;
    logic [TOTP_W-1:0]     totPlusOne;
    logic [TOT_W-1:0]      totalSat;
    logic [PERIOD_W-1:0]   periodNew;

    // Single input register; crossing detection runs on the registered copy.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sample_q <= 4'd0;
        end else begin
            sample_q <= sample_in;
        end
    end

`ifdef FREQ_METER_HYST_EN
    logic armed_q;

    // Arm once the waveform has been clearly low; a crossing needs it to
    // climb all the way to HI_TH, so dither around the midpoint cannot fire.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            armed_q <= 1'b0;
        end else if (xing) begin
            armed_q <= 1'b0;
        end else if (sample_q <= LO_Q) begin
            armed_q <= 1'b1;
        end
    end

    assign xing = armed_q && (sample_q >= HI_Q);
`else
    logic [3:0] samplePrev_q;

    // Previous registered sample, for edge detection on the midpoint.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            samplePrev_q <= 4'd0;
        end else begin
            samplePrev_q <= sample_q;
        end
    end

    assign xing = (samplePrev_q < MID_Q) && (sample_q >= MID_Q);
`endif

    // Total counter saturates rather than wrapping; the exact span between
    // first and last crossing is totCnt_q+1 at the final crossing, so that
    // sum is formed one bit wider and clamped before the divide.
    assign totInc     = (totCnt_q == {TOT_W{1'b1}}) ? totCnt_q : totCnt_q + TOT_W'(1);
    assign totPlusOne = {1'b0, totCnt_q} + TOTP_W'(1);
    assign totalSat   = totPlusOne[TOT_W] ? {TOT_W{1'b1}} : totPlusOne[TOT_W-1:0];
    assign periodNew  = PERIOD_W'(totalSat >> LOG2_NPER);

    // Next-state logic for the measurement sequencer.
    always_comb begin
        state_d     = state_q;
        totCnt_d    = totCnt_q;
        perCnt_d    = perCnt_q;
        tmoCnt_d    = tmoCnt_q;
        periodAvg_d = periodAvg_q;
        noSignal_d  = noSignal_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SYNC;
                    noSignal_d = 1'b0;
                    tmoCnt_d   = '0;
                end
            end

            SYNC: begin
                if (xing) begin
                    state_d  = COUNT;
                    totCnt_d = '0;
                    perCnt_d = '0;
                    tmoCnt_d = '0;
                end else if (tmoCnt_q == TMO_LAST) begin
                    state_d    = IDLE;
                    noSignal_d = 1'b1;
                end else begin
                    tmoCnt_d = tmoCnt_q + TIMEOUT_W'(1);
                end
            end

            COUNT: begin
                totCnt_d = totInc;
                tmoCnt_d = tmoCnt_q + TIMEOUT_W'(1);
                if (xing) begin
                    perCnt_d = perCnt_q + PER_W'(1);
                    tmoCnt_d = '0;
                    if (perCnt_q == NPER_LAST) begin
                        periodAvg_d = periodNew;
                        state_d     = DONE;
                    end
                end else if (tmoCnt_q == TMO_LAST) begin
                    state_d    = IDLE;
                    noSignal_d = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and counters.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            totCnt_q    <= '0;
            perCnt_q    <= '0;
            tmoCnt_q    <= '0;
            periodAvg_q <= '0;
            noSignal_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            totCnt_q    <= totCnt_d;
            perCnt_q    <= perCnt_d;
            tmoCnt_q    <= tmoCnt_d;
            periodAvg_q <= periodAvg_d;
            noSignal_q  <= noSignal_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign meas_valid = (state_q == DONE);
    assign period_avg = periodAvg_q;
    assign no_signal  = noSignal_q;

endmodule

// File: tb/tb_nco_freq_meter.sv
// ---------------------------------------------------------------------------
// Testbench for nco_freq_meter. A generator process plays one of several
// 4-bit waveforms into sample_in; the main initial block runs directed
// steps, pushing the expected period onto a scoreboard queue at each start
// and popping it when meas_valid appears.
// Waveforms: 64-clock sine, 65-clock sine (stretched peak), constant 7,
// 64-clock sine with 7/8/7/8 dither before the rise, 150-clock square.
// ---------------------------------------------------------------------------
module tb_nco_freq_meter;

    localparam int PERIOD_W  = 7;
    localparam int LOG2_NPER = 3;
    localparam int TIMEOUT_W = 8;

    localparam int W_SINE64 = 0;
    localparam int W_P65    = 1;
    localparam int W_CONST7 = 2;
    localparam int W_DITHER = 3;
    localparam int W_SQ150  = 4;

`ifdef FREQ_METER_HYST_EN
    // Crossing fires on the first sample reaching HI_TH (waveform phase 4).
    localparam int LAT_PH     = 5;
    localparam int DITHER_EXP = 64;
`else
    // Crossing fires on the first sample at MID (waveform phase 0).
    localparam int LAT_PH     = 1;
    localparam int DITHER_EXP = 32;
`endif

    logic                sys_clk = 1'b0;
    logic                sys_rst_n;
    logic                start;
    logic [3:0]          sample_in;
    logic                busy;
    logic                meas_valid;
    logic [PERIOD_W-1:0] period_avg;
    logic                no_signal;

    int          nChecks = 0;
    int          nFails  = 0;
    int          waveMode = W_SINE64;
    int          gPhase   = 0;
    logic [31:0] expQ[$];

    logic [3:0] sineTab [16] = '{4'd8, 4'd10, 4'd13, 4'd14, 4'd15, 4'd14, 4'd13, 4'd10,
                                 4'd7, 4'd5,  4'd2,  4'd1,  4'd0,  4'd1,  4'd2,  4'd5};

    always #5 sys_clk = ~sys_clk;

    nco_freq_meter #(
        .PERIOD_W  (PERIOD_W),
        .LOG2_NPER (LOG2_NPER),
        .TIMEOUT_W (TIMEOUT_W),
        .MID       (8),
        .HI_TH     (10),
        .LO_TH     (5)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .start      (start),
        .sample_in  (sample_in),
        .busy       (busy),
        .meas_valid (meas_valid),
        .period_avg (period_avg),
        .no_signal  (no_signal)
    );

    function automatic logic [3:0] waveValue(input int m, input int ph);
        int q;
        int idx;
        case (m)
            W_SINE64: return sineTab[(ph % 64) / 4];
            W_P65: begin
                q = ph % 65;
                if (q < 16)       idx = q / 4;
                else if (q <= 20) idx = 4;
                else              idx = (q - 1) / 4;
                return sineTab[idx];
            end
            W_CONST7: return 4'd7;
            W_DITHER: begin
                q = ph % 64;
                if (q >= 60) return ((q % 2) == 0) ? 4'd7 : 4'd8;
                return sineTab[q / 4];
            end
            W_SQ150:  return ((ph % 150) < 75) ? 4'd0 : 4'd15;
            default:  return 4'd0;
        endcase
    endfunction

    // Waveform generator: one sample per clock, driven on the falling edge;
    // the phase restarts whenever the waveform mode changes.
    initial begin
        int lastMode;
        lastMode  = waveMode;
        sample_in = waveValue(waveMode, 0);
        forever begin
            @(negedge sys_clk);
            if (waveMode != lastMode) begin
                lastMode = waveMode;
                gPhase   = 0;
            end else begin
                gPhase++;
            end
            sample_in = waveValue(waveMode, gPhase);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Switch waveform and let it run long enough that no mode-change glitch
    // can be mistaken for a crossing.
    task automatic applyStimulus(input int mode, input int settle);
        @(posedge sys_clk);
        waveMode = mode;
        repeat (settle) @(posedge sys_clk);
    endtask

    task automatic startPulse(input string tag);
        @(negedge sys_clk);
        start = 1'b1;
        @(posedge sys_clk);
        #1;
        checkOutput({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic waitMeas(input int budget, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < budget) begin
            @(posedge sys_clk);
            #1;
            cycles++;
            if (meas_valid === 1'b1) seen = 1'b1;
        end
    endtask

    // Pop the scoreboard against the DUT result in the meas_valid cycle, then
    // confirm the pulse is one cycle wide and busy drops right after DONE.
    task automatic scoreMeas(input string tag, input bit seen, input bit checkLat);
        logic [31:0] exp;
        nChecks++;
        assert (seen) else begin
            nFails++;
            $error("[TB] FAIL %s_meas_timeout: observed no meas_valid expected meas_valid", tag);
        end
        if (seen) begin
            nChecks++;
            assert (expQ.size() != 0) else begin
                nFails++;
                $error("[TB] FAIL %s_unexpected_meas: observed meas_valid expected none", tag);
            end
            if (expQ.size() != 0) begin
                exp = expQ.pop_front();
                checkOutput({tag, "_period_avg"}, 32'(period_avg), exp);
            end
            checkOutput({tag, "_busy_in_done"}, 32'(busy), 32'd1);
            if (checkLat) checkOutput({tag, "_latency_phase"}, 32'(gPhase % 64), 32'(LAT_PH));
            exp = 32'(period_avg);
            @(posedge sys_clk);
            #1;
            checkOutput({tag, "_meas_valid_width"}, 32'(meas_valid), 32'd0);
            checkOutput({tag, "_busy_after_done"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int  cycles;
        bit  seen;
        int  n;
        bit  sawMeas;
        bit  sawBusy;

        sys_rst_n = 1'b0;
        start     = 1'b0;
        $display("[TB] reset");
        repeat (3) @(negedge sys_clk);
        checkOutput("reset_busy",       32'(busy),       32'd0);
        checkOutput("reset_meas_valid", 32'(meas_valid), 32'd0);
        checkOutput("reset_period_avg", 32'(period_avg), 32'd0);
        checkOutput("reset_no_signal",  32'(no_signal),  32'd0);
        sys_rst_n = 1'b1;

        // Period-64 sine
        $display("[TB] step: sine period 64");
        applyStimulus(W_SINE64, 150);
        startPulse("sine64");
        expQ.push_back(32'd64);
        waitMeas(2000, cycles, seen);
        scoreMeas("sine64", seen, 1'b1);

        // Period-65 sine: 520 clocks over 8 periods
        $display("[TB] step: sine period 65");
        applyStimulus(W_P65, 200);
        startPulse("p65");
        expQ.push_back(32'd65);
        waitMeas(2000, cycles, seen);
        if (seen) checkOutput("p65_latency_phase", 32'(gPhase % 65), 32'(LAT_PH));
        scoreMeas("p65", seen, 1'b0);

        // Start re-pulsed during COUNT must not restart the measurement
        $display("[TB] step: start re-pulsed during COUNT");
        applyStimulus(W_SINE64, 150);
        startPulse("repulse");
        expQ.push_back(32'd64);
        waitMeas(120, cycles, seen);
        n = cycles;
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        n++;
        waitMeas(2000, cycles, seen);
        n += cycles;
        checkOutput("repulse_no_restart", 32'(n >= 512 && n <= 580), 32'd1);
        scoreMeas("repulse", seen, 1'b1);

        // Constant input: timeout 255 clocks after SYNC entry
        $display("[TB] step: timeout on constant input");
        applyStimulus(W_CONST7, 10);
        startPulse("timeout");
        n       = 0;
        sawMeas = 1'b0;
        while (n < 400 && no_signal !== 1'b1) begin
            @(posedge sys_clk);
            #1;
            n++;
            if (meas_valid === 1'b1) sawMeas = 1'b1;
        end
        checkOutput("timeout_clocks",     32'(n),          32'd255);
        checkOutput("timeout_no_meas",    32'(sawMeas),    32'd0);
        checkOutput("timeout_period_hold", 32'(period_avg), 32'd64);
        checkOutput("timeout_busy",       32'(busy),       32'd0);

        // Dither near the midpoint; also confirms start clears no_signal
        $display("[TB] step: dithered sine");
        applyStimulus(W_DITHER, 150);
        startPulse("dither");
        checkOutput("dither_no_signal_cleared", 32'(no_signal), 32'd0);
        expQ.push_back(32'(DITHER_EXP));
        waitMeas(2000, cycles, seen);
        scoreMeas("dither", seen, 1'b0);

        // 1200 clocks over 8 periods overflows the 10-bit total: saturates
        $display("[TB] step: total counter saturation");
        applyStimulus(W_SQ150, 300);
        startPulse("saturate");
        expQ.push_back(32'd127);
        waitMeas(2500, cycles, seen);
        scoreMeas("saturate", seen, 1'b0);

        // Reset in the middle of COUNT discards the measurement
        $display("[TB] step: reset during COUNT");
        applyStimulus(W_SINE64, 150);
        startPulse("midreset");
        expQ.push_back(32'd64);
        repeat (200) @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy",       32'(busy),       32'd0);
        checkOutput("midreset_meas_valid", 32'(meas_valid), 32'd0);
        checkOutput("midreset_period_avg", 32'(period_avg), 32'd0);
        checkOutput("midreset_no_signal",  32'(no_signal),  32'd0);
        expQ.delete();
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        sawMeas = 1'b0;
        sawBusy = 1'b0;
        repeat (700) begin
            @(posedge sys_clk);
            #1;
            if (meas_valid === 1'b1) sawMeas = 1'b1;
            if (busy === 1'b1)       sawBusy = 1'b1;
        end
        checkOutput("midreset_stays_idle", 32'(sawMeas | sawBusy), 32'd0);
        startPulse("after_reset");
        expQ.push_back(32'd64);
        waitMeas(2000, cycles, seen);
        scoreMeas("after_reset", seen, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
